fft_reorder_pp: RTL and testbench

- Parametrised ping-pong reorder buffer placed directly after the streaming FFT core. It takes one frame of N complex samples from the core's in_valid/din_r/din_i stream.
- Per frame it either un-scrambles bit-reversed order to natural order, or passes the frame through in arrival order.
- Adds output backpressure (out_ready), frame markers and overflow detection, none of which the bare FFT stream interface has.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_pingpong_ram.sv | 27 ++
 rtl/fft_reorder_pp.sv | 158 +++++++++++++++
 tb/tb_fft_reorder_pp.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, complex sample type and the
// bit-reversal helper used by the FFT core and its reorder buffer.
package fft_pkg;

   localparam int LOG2N_DEF = 8;
   localparam int WIDTH_DEF = 16;
   localparam int LOG2N_MAX = 12;

   typedef struct packed {
      logic signed [WIDTH_DEF-1:0] re;
      logic signed [WIDTH_DEF-1:0] im;
   } cplx_t;

   // Reverse the low 'bits' bits of value; upper bits come back as 0.
   function automatic logic [LOG2N_MAX-1:0] bitrev(
      input logic [LOG2N_MAX-1:0] value,
      input int                   bits
   );
      logic [LOG2N_MAX-1:0] r;
      logic [3:0]           src;
      r = '0;
      for (int i = 0; i < LOG2N_MAX; i++) begin
         src = 4'(bits - 1 - i);
         if (i < bits) r[4'(i)] = value[src];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store for the reorder buffer, addressed by {bank, index}.
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read.
module fft_pingpong_ram
   import fft_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               we,
   input  logic [LOG2N:0]     waddr,
   input  logic [2*WIDTH-1:0] wdata,
   input  logic [LOG2N:0]     raddr,
   output logic [2*WIDTH-1:0] rdata
);

   localparam int DEPTH = 2 ** (LOG2N + 1);

   logic [2*WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_reorder_pp.sv
// Ping-pong reorder buffer after the streaming FFT: bit-reversed to
// natural order (mode=0) or pass-through (mode=1), per frame.
// Ports: clk, rst_n (sync, active low); mode/in_valid/din_r/din_i input
// stream; out_ready backpressure; out_valid/dout_r/dout_i/out_first/
// out_last output stream; overflow sticky drop flag.
module fft_reorder_pp
   import fft_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] din_r,
   input  logic [WIDTH-1:0] din_i,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] dout_r,
   output logic [WIDTH-1:0] dout_i,
   output logic             out_first,
   output logic             out_last,
   output logic             overflow
);

   localparam logic [LOG2N-1:0] LAST = LOG2N'(2 ** LOG2N - 1);

   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic             wr_mode_q, wr_mode_d;
   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
   logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             out_first_q, out_first_d;
   logic             out_last_q, out_last_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] dout_r_q, dout_r_d;
   logic [WIDTH-1:0] dout_i_q, dout_i_d;

   logic               accept;
   logic               drop;
   logic               load;
   logic               frame_mode;
   logic [LOG2N-1:0]   wr_idx;
   logic [LOG2N:0]     waddr;
   logic [LOG2N:0]     raddr;
   logic [2*WIDTH-1:0] rdata;

   fft_pingpong_ram #(
      .LOG2N (LOG2N),
      .WIDTH (WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (waddr),
      .wdata ({din_r, din_i}),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_comb begin
      accept = in_valid & ~full_q[wr_bank_q];
      drop   = in_valid & full_q[wr_bank_q];
      load   = full_q[rd_bank_q] & (~out_valid_q | out_ready);

      // First sample of a frame uses live mode; later ones the latch.
      frame_mode = (wr_cnt_q == '0) ? mode : wr_mode_q;
      wr_idx = frame_mode ? wr_cnt_q
             : LOG2N'(bitrev(LOG2N_MAX'(wr_cnt_q), LOG2N));
      waddr  = {wr_bank_q, wr_idx};
      raddr  = {rd_bank_q, rd_cnt_q};

      full_d      = full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_mode_d   = wr_mode_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      out_valid_d = out_valid_q;
      out_first_d = out_first_q;
      out_last_d  = out_last_q;
      overflow_d  = overflow_q;
      dout_r_d    = dout_r_q;
      dout_i_d    = dout_i_q;

      if (accept) begin
         wr_mode_d = frame_mode;
         if (wr_cnt_q == LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d = ~wr_bank_q;
            wr_cnt_d  = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end

      if (drop) overflow_d = 1'b1;

      // Set and clear above never target the same bank: a bank being
      // written is not full, so it cannot be the one being read.
      if (load) begin
         dout_r_d    = rdata[2*WIDTH-1:WIDTH];
         dout_i_d    = rdata[WIDTH-1:0];
         out_valid_d = 1'b1;
         out_first_d = (rd_cnt_q == '0);
         out_last_d  = (rd_cnt_q == LAST);
         if (rd_cnt_q == LAST) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d = ~rd_bank_q;
            rd_cnt_d  = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_mode_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
         dout_r_q    <= '0;
         dout_i_q    <= '0;
      end else begin
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_mode_q   <= wr_mode_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         out_valid_q <= out_valid_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
         overflow_q  <= overflow_d;
         dout_r_q    <= dout_r_d;
         dout_i_q    <= dout_i_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;
   assign overflow  = overflow_q;
   assign dout_r    = dout_r_q;
   assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_fft_reorder_pp.sv
// Bench for fft_reorder_pp: LOG2N=3 and LOG2N=8 instances share one
// stimulus stream and are compared every cycle with a frame-queue model.
module tb_fft_reorder_pp;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic        in_valid;
   logic [15:0] din_r;
   logic [15:0] din_i;
   logic        out_ready;

   logic        ov3, of3, ol3, ovf3;
   logic [15:0] dr3, di3;
   logic        ov8, of8, ol8, ovf8;
   logic [15:0] dr8, di8;

   int checks;
   int failures;
   int cyc;
   int first_v3;
   int first_v8;
   int last_v8;
   int v8_cnt;
   int t0;

   logic [15:0] q3[$];
   logic [15:0] q8[$];

   // Reference model state, index 0 = LOG2N 3, index 1 = LOG2N 8.
   logic [31:0] frmq [2][$];
   logic [31:0] cur [2][256];
   int          cur_cnt [2];
   int          rd_pos [2];
   bit          cur_mode [2];
   bit          mv [2];
   bit          mf [2];
   bit          ml [2];
   bit          mo [2];
   logic [31:0] md [2];

   int ord3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
   int pt3 [16] = '{10, 11, 12, 13, 14, 15, 16, 17,
                    20, 24, 22, 26, 21, 25, 23, 27};

   fft_reorder_pp #(.LOG2N(3), .WIDTH(16)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .din_r     (din_r),
      .din_i     (din_i),
      .out_ready (out_ready),
      .out_valid (ov3),
      .dout_r    (dr3),
      .dout_i    (di3),
      .out_first (of3),
      .out_last  (ol3),
      .overflow  (ovf3)
   );

   fft_reorder_pp #(.LOG2N(8), .WIDTH(16)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .din_r     (din_r),
      .din_i     (din_i),
      .out_ready (out_ready),
      .out_valid (ov8),
      .dout_r    (dr8),
      .dout_i    (di8),
      .out_first (of8),
      .out_last  (ol8),
      .overflow  (ovf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int rev(int v, int bits);
      int r;
      r = 0;
      for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
      return r;
   endfunction

   // One clock edge of the model, using pre-edge inputs and state.
   task automatic mstep(int d);
      int n, lg, nf;
      bit ld, acc, drp;
      n  = (d == 0) ? 8 : 256;
      lg = (d == 0) ? 3 : 8;
      if (!rst_n) begin
         frmq[d].delete();
         cur_cnt[d] = 0;
         rd_pos[d]  = 0;
         mv[d] = 0; mf[d] = 0; ml[d] = 0; mo[d] = 0;
         md[d] = '0;
         return;
      end
      nf  = frmq[d].size() / n;
      ld  = (nf > 0) && (!mv[d] || out_ready);
      acc = in_valid && (nf < 2);
      drp = in_valid && (nf == 2);
      if (ld) begin
         md[d] = frmq[d][rd_pos[d]];
         mf[d] = (rd_pos[d] == 0);
         ml[d] = (rd_pos[d] == n - 1);
         mv[d] = 1;
         rd_pos[d]++;
         if (rd_pos[d] == n) begin
            rd_pos[d] = 0;
            repeat (n) void'(frmq[d].pop_front());
         end
      end else if (out_ready) begin
         mv[d] = 0;
      end
      if (acc) begin
         if (cur_cnt[d] == 0) cur_mode[d] = mode;
         cur[d][cur_cnt[d]] = {din_r, din_i};
         cur_cnt[d]++;
         if (cur_cnt[d] == n) begin
            for (int j = 0; j < n; j++)
               frmq[d].push_back(cur_mode[d] ? cur[d][j]
                                             : cur[d][rev(j, lg)]);
            cur_cnt[d] = 0;
         end
      end
      if (drp) mo[d] = 1;
   endtask

   task automatic tick();
      if (ov3 && out_ready) q3.push_back(dr3);
      if (ov8 && out_ready) q8.push_back(dr8);
      mstep(0);
      mstep(1);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (ov3 && first_v3 < 0) first_v3 = cyc;
      if (ov8) begin
         if (first_v8 < 0) first_v8 = cyc;
         last_v8 = cyc;
         v8_cnt++;
      end
      chk("l3_cycle", {ov3, of3, ol3, ovf3, dr3, di3},
          {mv[0], mf[0], ml[0], mo[0], md[0]});
      chk("l8_cycle", {ov8, of8, ol8, ovf8, dr8, di8},
          {mv[1], mf[1], ml[1], mo[1], md[1]});
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      q3.delete();
      q8.delete();
      first_v3 = -1;
      first_v8 = -1;
      last_v8  = -1;
      v8_cnt   = 0;
   endtask

   task automatic drain(int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0;
      rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0;
      din_r = '0; din_i = '0; out_ready = 1'b1;
      @(negedge clk);

      // Reset values.
      do_reset();
      do_reset();
      chk("rst_out3", {ov3, of3, ol3, ovf3, dr3, di3}, '0);
      chk("rst_out8", {ov8, of8, ol8, ovf8, dr8, di8}, '0);

      // Bit-reversed order and latency.
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; mode = 1'b0;
         din_r = 16'(k); din_i = '0;
         tick();
         if (k == 0) t0 = cyc;
      end
      drain(20);
      chk("order_lat", 64'(first_v3 - t0 + 1), 64'd9);
      chk("order_cnt", 64'(q3.size()), 64'd8);
      for (int i = 0; i < 8 && i < q3.size(); i++)
         chk("order_re", q3[i], 64'(ord3[i]));

      // Pass-through with mid-frame mode flip, then mode 0 frame.
      do_reset();
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1;
         mode  = (k < 3);
         din_r = (k < 8) ? 16'(10 + k) : 16'(12 + k);
         din_i = 16'($urandom);
         tick();
      end
      drain(30);
      chk("pass_cnt", 64'(q3.size()), 64'd16);
      for (int i = 0; i < 16 && i < q3.size(); i++)
         chk("pass_re", q3[i], 64'(pt3[i]));

      // Backpressure hold on sample 0.
      do_reset();
      out_ready = 1'b1; mode = 1'b0;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; din_r = 16'(k); din_i = 16'(100 + k);
         tick();
      end
      in_valid = 1'b0;
      for (int w = 0; w < 20 && !ov3; w++) tick();
      chk("bp_wait", ov3, 1);
      out_ready = 1'b0;
      repeat (4) begin
         tick();
         chk("bp_hold", {ov3, of3, dr3, di3}, {2'b11, 16'd0, 16'd100});
      end
      out_ready = 1'b1;
      drain(20);
      chk("bp_cnt", 64'(q3.size()), 64'd8);
      for (int i = 0; i < 8 && i < q3.size(); i++)
         chk("bp_re", q3[i], 64'(ord3[i]));

      // Overflow with both banks full.
      do_reset();
      out_ready = 1'b0; mode = 1'b0;
      for (int k = 0; k < 17; k++) begin
         in_valid = 1'b1; din_r = 16'(k); din_i = '0;
         tick();
         if (k == 15) chk("ovf_before", ovf3, 0);
         if (k == 16) chk("ovf_set", ovf3, 1);
      end
      drain(5);
      chk("ovf_sticky", ovf3, 1);
      chk("ovf_first", {ov3, of3, dr3}, {2'b11, 16'd0});
      out_ready = 1'b1;
      drain(40);
      chk("ovf_cnt", 64'(q3.size()), 64'd16);
      for (int i = 0; i < 16 && i < q3.size(); i++)
         chk("ovf_re", q3[i], 64'(ord3[i % 8] + (i / 8) * 8));
      chk("ovf_hold", ovf3, 1);

      // Reset in the middle of a frame.
      do_reset();
      out_ready = 1'b1; mode = 1'b0;
      for (int k = 0; k < 100; k++) begin
         in_valid = 1'b1; din_r = 16'(k); din_i = 16'($urandom);
         tick();
      end
      rst_n = 1'b0; in_valid = 1'b0;
      tick();
      chk("rstmid_out8", {ov8, of8, ol8, ovf8, dr8, di8}, '0);
      chk("rstmid_out3", {ov3, of3, ol3, ovf3, dr3, di3}, '0);
      rst_n = 1'b1;
      q8.delete();
      for (int k = 0; k < 256; k++) begin
         in_valid = 1'b1; din_r = 16'(k); din_i = 16'($urandom);
         tick();
      end
      drain(300);
      chk("rstmid_cnt", 64'(q8.size()), 64'd256);
      for (int j = 0; j < 256 && j < q8.size(); j++)
         chk("rstmid_re", q8[j], 64'(rev(j, 8)));
      chk("rstmid_ovf", ovf8, 0);

      // Three back-to-back 256-sample frames at full rate.
      do_reset();
      out_ready = 1'b1; mode = 1'b0;
      for (int k = 0; k < 768; k++) begin
         in_valid = 1'b1;
         din_r = 16'($urandom); din_i = 16'($urandom);
         tick();
      end
      drain(300);
      chk("b2b_cnt", 64'(q8.size()), 64'd768);
      chk("b2b_gapless", 64'(last_v8 - first_v8 + 1), 64'd768);
      chk("b2b_ovf", ovf8, 0);

      // Random traffic, modes and backpressure.
      do_reset();
      repeat (4000) begin
         in_valid  = ($urandom_range(0, 9) < 8);
         mode      = $urandom_range(0, 1) == 1;
         out_ready = ($urandom_range(0, 9) < 7);
         din_r = 16'($urandom); din_i = 16'($urandom);
         tick();
      end
      out_ready = 1'b1;
      drain(600);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
